// File: rtl/imem_boot_loader.sv
// Boot loader: takes a length-prefixed byte image, writes big-endian words into
// instruction memory and holds the core in reset until the image checksum verifies.
module imem_boot_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CKSUM,
        DONE,
        ERROR
    } state_t;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       CAPACITY = 32'd1 << ADDR_W;

    state_t              state_q, state_d;
    logic [15:0]         n_q, n_d;
    logic [23:0]         word_q, word_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [7:0]          cksum_q, cksum_d;
    logic                rx_ready_q, rx_ready_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;
    logic                core_rst_q, core_rst_d;
    logic                load_done_q, load_done_d;
    logic                load_err_q, load_err_d;
    logic [ADDR_W:0]     words_loaded_q, words_loaded_d;

    logic                accept;
    logic [15:0]         n_rx;

    assign accept = rx_valid && rx_ready_q;
    assign n_rx   = {n_q[15:8], rx_data};

    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        word_d         = word_q;
        byte_idx_d     = byte_idx_q;
        cksum_d        = cksum_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        core_rst_d     = core_rst_q;
        load_done_d    = load_done_q;
        load_err_d     = load_err_q;
        words_loaded_d = words_loaded_q;

        case (state_q)
            HDR_HI: begin
                if (accept) begin
                    n_d[15:8] = rx_data;
                    state_d   = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    n_d        = n_rx;
                    byte_idx_d = 2'd0;
                    if ({16'd0, n_rx} > CAPACITY) begin
                        state_d    = ERROR;
                        load_err_d = 1'b1;
                    end else if (n_rx == 16'd0) begin
                        state_d = CKSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    cksum_d    = cksum_q ^ rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Fourth byte completes the word; the write lands next cycle.
                        imem_we_d      = 1'b1;
                        imem_wdata_d   = {word_q, rx_data};
                        imem_addr_d    = BASE + words_loaded_q[ADDR_W-1:0];
                        words_loaded_d = words_loaded_q + (ADDR_W+1)'(1);
                        if (32'(words_loaded_q) + 32'd1 == {16'd0, n_q}) begin
                            state_d = CKSUM;
                        end
                    end else begin
                        word_d = {word_q[15:0], rx_data};
                    end
                end
            end
            CKSUM: begin
                if (accept) begin
                    if (rx_data == cksum_q) begin
                        state_d     = DONE;
                        load_done_d = 1'b1;
                        core_rst_d  = 1'b0;
                    end else begin
                        state_d    = ERROR;
                        load_err_d = 1'b1;
                    end
                end
            end
            DONE, ERROR: begin
                if (start) begin
                    state_d        = HDR_HI;
                    byte_idx_d     = 2'd0;
                    cksum_d        = 8'd0;
                    words_loaded_d = '0;
                    load_done_d    = 1'b0;
                    load_err_d     = 1'b0;
                    core_rst_d     = 1'b1;
                end
            end
            default: ;
        endcase

        rx_ready_d = (state_d == HDR_HI) || (state_d == HDR_LO) ||
                     (state_d == DATA)   || (state_d == CKSUM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= HDR_HI;
            n_q            <= 16'd0;
            word_q         <= 24'd0;
            byte_idx_q     <= 2'd0;
            cksum_q        <= 8'd0;
            rx_ready_q     <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= BASE;
            imem_wdata_q   <= 32'd0;
            core_rst_q     <= 1'b1;
            load_done_q    <= 1'b0;
            load_err_q     <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            word_q         <= word_d;
            byte_idx_q     <= byte_idx_d;
            cksum_q        <= cksum_d;
            rx_ready_q     <= rx_ready_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            core_rst_q     <= core_rst_d;
            load_done_q    <= load_done_d;
            load_err_q     <= load_err_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_rst     = core_rst_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_loaded_q;

endmodule
